// File: rtl/tlc_fsm_param.sv
// tlc_fsm_param
//   Highway/farm-road traffic-light controller.  It contains its own prescaler
//   and dwell timer, so every phase is timed internally.  The farm green has
//   a minimum, a maximum and a gap-out.  An emergency request pre-empts the
//   cycle to an all-red hold, always through the active road's yellow.
//
// Ports
//   Clk            in   clock, rising edge
//   Rst            in   synchronous, active-high reset
//   farmSensor     in   vehicle waiting on the farm road (already synchronised)
//   emerg          in   emergency pre-empt request, level-sensitive
//   highwaySignal  out  highway lamp code: 01 red, 11 green, 10 yellow
//   farmSignal     out  farm lamp code, same encoding
//   state          out  current state (debug)
//   timer          out  ticks elapsed in the current state, saturating (debug)
//   tick           out  one-cycle prescaler strobe (debug)
//
// Handshake: none.  farmSensor is only looked at on tick cycles.  emerg is
// looked at on every cycle.  Each decision takes effect on the next edge.
module tlc_fsm_param #(
    parameter int TICK_DIV   = 1,
    parameter int TW         = 5,
    parameter int ALLRED_T   = 1,
    parameter int HWY_MIN    = 30,
    parameter int HWY_YEL_T  = 3,
    parameter int FARM_MIN   = 3,
    parameter int FARM_MAX   = 15,
    parameter int FARM_YEL_T = 3
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic          farmSensor,
    input  logic          emerg,
    output logic [1:0]    highwaySignal,
    output logic [1:0]    farmSignal,
    output logic [2:0]    state,
    output logic [TW-1:0] timer,
    output logic          tick
);

    typedef enum logic [2:0] {
        S_AR1 = 3'b000,
        S_HG  = 3'b001,
        S_HY  = 3'b010,
        S_AR2 = 3'b011,
        S_FG  = 3'b100,
        S_FY  = 3'b101,
        S_PRE = 3'b110,
        S_RST = 3'b111
    } state_t;

    localparam int              PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]   PRE_LAST  = PW'(TICK_DIV - 1);
    localparam logic [TW-1:0]   TMAX      = '1;
    localparam logic [1:0]      LAMP_RED  = 2'b01;
    localparam logic [1:0]      LAMP_GRN  = 2'b11;
    localparam logic [1:0]      LAMP_YEL  = 2'b10;

    state_t        cur;
    state_t        nxt;
    logic [PW-1:0] presc;
    logic [TW:0]   elapsed;   // ticks completed once the current tick lands
    logic          allred_done;
    logic          hwy_yel_done;
    logic          farm_yel_done;

    // The reset state has no timing, so the strobe is held low there.
    assign tick    = (cur != S_RST) && (presc == PRE_LAST);
    assign elapsed = {1'b0, timer} + (TW+1)'(1);

    // A duration D is reached on the tick where the timer reads D-1.
    assign allred_done   = tick && (timer == TW'(ALLRED_T - 1));
    assign hwy_yel_done  = tick && (timer == TW'(HWY_YEL_T - 1));
    assign farm_yel_done = tick && (timer == TW'(FARM_YEL_T - 1));

    always_comb begin
        nxt = cur;
        case (cur)
            S_RST: nxt = S_AR1;
            S_AR1: begin
                if (emerg)            nxt = S_PRE;
                else if (allred_done) nxt = S_HG;
            end
            S_HG: begin
                // Pre-emption leaves the highway through its yellow.
                if (emerg) nxt = S_HY;
                else if (tick && farmSensor && (elapsed >= (TW+1)'(HWY_MIN))) nxt = S_HY;
            end
            S_HY: begin
                if (hwy_yel_done) nxt = emerg ? S_PRE : S_AR2;
            end
            S_AR2: begin
                if (emerg)            nxt = S_PRE;
                else if (allred_done) nxt = S_FG;
            end
            S_FG: begin
                if (emerg) nxt = S_FY;
                else if (tick && ((elapsed == (TW+1)'(FARM_MAX)) ||
                                  ((elapsed >= (TW+1)'(FARM_MIN)) && !farmSensor)))
                    nxt = S_FY;
            end
            S_FY: begin
                if (farm_yel_done) nxt = emerg ? S_PRE : S_AR1;
            end
            S_PRE: begin
                if (!emerg) nxt = S_AR1;
            end
            default: nxt = S_RST;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            cur   <= S_RST;
            presc <= '0;
            timer <= '0;
        end else if (nxt != cur) begin
            // Every phase starts its timing from zero.
            cur   <= nxt;
            presc <= '0;
            timer <= '0;
        end else begin
            presc <= (presc == PRE_LAST) ? '0 : presc + PW'(1);
            if (tick && (timer != TMAX))
                timer <= timer + TW'(1);
        end
    end

    assign state = cur;

    always_comb begin
        highwaySignal = LAMP_RED;
        farmSignal    = LAMP_RED;
        case (cur)
            S_HG:    highwaySignal = LAMP_GRN;
            S_HY:    highwaySignal = LAMP_YEL;
            S_FG:    farmSignal    = LAMP_GRN;
            S_FY:    farmSignal    = LAMP_YEL;
            default: begin
                highwaySignal = LAMP_RED;
                farmSignal    = LAMP_RED;
            end
        endcase
    end

endmodule

// File: tb/tb_tlc_fsm_param.sv
// tb_tlc_fsm_param
//   Bench for tlc_fsm_param.  Two instances share the stimulus: one with
//   TICK_DIV=1 and one with TICK_DIV=4.  The reference model tracks each
//   instance by phase name and the number of cycles spent in that phase.
//   Timer, tick and exit times are derived from that count by division.
module tb_tlc_fsm_param;

    localparam int TW = 5;
    localparam int W  = 13;   // {state, highway, farm, timer, tick}

    // Phase codes as given for the debug state output.
    localparam int P_AR1 = 0, P_HG = 1, P_HY = 2, P_AR2 = 3;
    localparam int P_FG  = 4, P_FY = 5, P_PRE = 6, P_SRST = 7;

    localparam int ALLRED_T = 1, HWY_MIN = 30, HWY_YEL_T = 3;
    localparam int FARM_MIN = 3, FARM_MAX = 15, FARM_YEL_T = 3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst  = 1'b1;
    logic farm = 1'b0;
    logic em   = 1'b0;

    logic [1:0]    hw1, fm1, hw4, fm4;
    logic [2:0]    st1, st4;
    logic [TW-1:0] tm1, tm4;
    logic          tk1, tk4;

    tlc_fsm_param #(.TICK_DIV(1)) u_d1 (
        .Clk(clk), .Rst(rst), .farmSensor(farm), .emerg(em),
        .highwaySignal(hw1), .farmSignal(fm1), .state(st1), .timer(tm1), .tick(tk1)
    );

    tlc_fsm_param #(.TICK_DIV(4)) u_d4 (
        .Clk(clk), .Rst(rst), .farmSensor(farm), .emerg(em),
        .highwaySignal(hw4), .farmSignal(fm4), .state(st4), .timer(tm4), .tick(tk4)
    );

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;
    int ncyc  = 0;
    logic [W-1:0] exp_q[$];
    int  ph[2];
    int  cyc[2];
    bit  valid = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, ncyc);
        end
    endtask

    function automatic int hw_of(input int p);
        if (p == P_HG) return 3;
        if (p == P_HY) return 2;
        return 1;
    endfunction

    function automatic int fm_of(input int p);
        if (p == P_FG) return 3;
        if (p == P_FY) return 2;
        return 1;
    endfunction

    function automatic logic [W-1:0] expect_of(input int p, input int c, input int div);
        int t;
        logic tk;
        t  = c / div;
        if (t > 31) t = 31;
        tk = (p != P_SRST) && ((c % div) == div - 1);
        return {3'(p), 2'(hw_of(p)), 2'(fm_of(p)), 5'(t), tk};
    endfunction

    // One clock edge of the reference model for instance k.
    task automatic model_step(input int div, input int k);
        int p, c, np, done;
        bit tk;
        p    = ph[k];
        c    = cyc[k];
        tk   = (p != P_SRST) && ((c % div) == div - 1);
        done = c / div + 1;   // ticks completed if this cycle is a tick
        np   = p;
        if (rst) np = P_SRST;
        else begin
            case (p)
                P_SRST: np = P_AR1;
                P_AR1:  if (em) np = P_PRE; else if (tk && done == ALLRED_T) np = P_HG;
                P_HG:   if (em) np = P_HY;  else if (tk && farm && done >= HWY_MIN) np = P_HY;
                P_HY:   if (tk && done == HWY_YEL_T) np = em ? P_PRE : P_AR2;
                P_AR2:  if (em) np = P_PRE; else if (tk && done == ALLRED_T) np = P_FG;
                P_FG:   if (em) np = P_FY;
                        else if (tk && (done == FARM_MAX || (done >= FARM_MIN && !farm))) np = P_FY;
                P_FY:   if (tk && done == FARM_YEL_T) np = em ? P_PRE : P_AR1;
                P_PRE:  if (!em) np = P_AR1;
                default: np = P_SRST;
            endcase
        end
        if (rst || np != p) c = 0;
        else c = c + 1;
        ph[k]  = np;
        cyc[k] = c;
    endtask

    // Advance one edge, step the model, compare both instances 1 time unit later.
    task automatic cycle();
        logic [W-1:0] e1, e4, g1, g4;
        @(posedge clk);
        ncyc++;
        if (rst) valid = 1'b1;
        if (valid) begin
            model_step(1, 0);
            model_step(4, 1);
            exp_q.push_back(expect_of(ph[0], cyc[0], 1));
            exp_q.push_back(expect_of(ph[1], cyc[1], 4));
        end
        #1;
        if (valid) begin
            g1 = {st1, hw1, fm1, tm1, tk1};
            g4 = {st4, hw4, fm4, tm4, tk4};
            e1 = exp_q.pop_front();
            e4 = exp_q.pop_front();
            total += 2;
            if (g1 !== e1) begin
                bad++;
                $display("FAIL model_div1: got %h expected %h (cycle %0d)", g1, e1, ncyc);
            end
            if (g4 !== e4) begin
                bad++;
                $display("FAIL model_div4: got %h expected %h (cycle %0d)", g4, e4, ncyc);
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        farm = 1'b0;
        em   = 1'b0;
        rst  = 1'b1;
        cycle();
        cycle();
        rst  = 1'b0;
    endtask

    function automatic logic [2:0] st_of(input int k);
        return (k == 0) ? st1 : st4;
    endfunction

    task automatic run_until(input int k, input int s, input int budget, input string name);
        int n;
        n = 0;
        while (int'(st_of(k)) != s && n < budget) begin
            cycle();
            n++;
        end
        chk(name, int'(st_of(k)), s);
    endtask

    // Counts consecutive samples spent in state s, starting with the current one.
    task automatic count_in(input int k, input int s, input int budget, output int n);
        n = 0;
        while (int'(st_of(k)) == s && n < budget) begin
            n++;
            cycle();
        end
    endtask

    typedef struct {
        logic       rst;
        logic       farm;
        logic       em;
        logic [2:0] st;
        logic [1:0] hw;
        logic [1:0] fm;
        logic [4:0] tmr;
    } vec_t;

    vec_t vecs[20];

    initial begin
        int n;
        int tcount;

        // ---------- table: reset, first pass, pre-emption, gap-out ----------
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 3'd7, 2'b01, 2'b01, 5'd0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 3'd7, 2'b01, 2'b01, 5'd0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 3'd0, 2'b01, 2'b01, 5'd0};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 3'd1, 2'b11, 2'b01, 5'd0};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 3'd1, 2'b11, 2'b01, 5'd1};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 3'd1, 2'b11, 2'b01, 5'd2};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 3'd2, 2'b10, 2'b01, 5'd0};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 3'd2, 2'b10, 2'b01, 5'd1};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 3'd2, 2'b10, 2'b01, 5'd2};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 3'd3, 2'b01, 2'b01, 5'd0};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 3'd4, 2'b01, 2'b11, 5'd0};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 3'd4, 2'b01, 2'b11, 5'd1};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 3'd4, 2'b01, 2'b11, 5'd2};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 3'd5, 2'b01, 2'b10, 5'd0};
        vecs[14] = '{1'b0, 1'b0, 1'b0, 3'd5, 2'b01, 2'b10, 5'd1};
        vecs[15] = '{1'b0, 1'b0, 1'b0, 3'd5, 2'b01, 2'b10, 5'd2};
        vecs[16] = '{1'b0, 1'b0, 1'b0, 3'd0, 2'b01, 2'b01, 5'd0};
        vecs[17] = '{1'b0, 1'b0, 1'b1, 3'd6, 2'b01, 2'b01, 5'd0};
        vecs[18] = '{1'b0, 1'b0, 1'b1, 3'd6, 2'b01, 2'b01, 5'd1};
        vecs[19] = '{1'b0, 1'b0, 1'b0, 3'd0, 2'b01, 2'b01, 5'd0};

        for (int i = 0; i < 20; i++) begin
            rst  = vecs[i].rst;
            farm = vecs[i].farm;
            em   = vecs[i].em;
            cycle();
            chk($sformatf("vec%0d_state", i), int'(st1), int'(vecs[i].st));
            chk($sformatf("vec%0d_lamps", i), int'({hw1, fm1}), int'({vecs[i].hw, vecs[i].fm}));
            chk($sformatf("vec%0d_timer", i), int'(tm1), int'(vecs[i].tmr));
        end

        // ---------- highway holds green without a request ----------
        do_reset();
        run_until(0, P_HG, 10, "reach_hg");
        n = 0;
        for (int i = 0; i < 100; i++) begin
            cycle();
            if (st1 == 3'd1 && fm1 == 2'b01) n++;
        end
        chk("hg_held_100", n, 100);
        chk("hg_timer_sat", int'(tm1), 31);

        // ---------- farm request at HG timer=10, then max farm green ----------
        do_reset();
        run_until(0, P_HG, 10, "reach_hg2");
        n = 0;
        while (tm1 != 5'd10 && n < 20) begin
            cycle();
            n++;
        end
        chk("hg_timer10", int'(tm1), 10);
        farm = 1'b1;
        count_in(0, P_HG, 60, n);
        chk("hg_rest_len", n, HWY_MIN - 10);
        count_in(0, P_HY, 20, n);
        chk("hy_len", n, HWY_YEL_T);
        count_in(0, P_AR2, 20, n);
        chk("ar2_len", n, ALLRED_T);
        chk("fg_entered", int'(st1), P_FG);
        count_in(0, P_FG, 40, n);
        chk("fg_max_len", n, FARM_MAX);

        // ---------- gap-out: farm dropped at FG timer=0 ----------
        run_until(0, P_FG, 80, "reach_fg2");
        farm = 1'b0;
        count_in(0, P_FG, 40, n);
        chk("fg_gapout_len", n, FARM_MIN);
        chk("fy_after_gap", int'(st1), P_FY);

        // ---------- emergency during HG timer=5 ----------
        do_reset();
        run_until(0, P_HG, 10, "reach_hg3");
        repeat (5) cycle();
        chk("hg_timer5", int'(tm1), 5);
        em = 1'b1;
        cycle();
        chk("emerg_to_hy", int'(st1), P_HY);
        count_in(0, P_HY, 20, n);
        chk("emerg_hy_len", n, HWY_YEL_T);
        chk("emerg_pre", int'(st1), P_PRE);
        repeat (4) cycle();
        chk("pre_hold", int'(st1), P_PRE);
        em = 1'b0;
        cycle();
        chk("pre_to_ar1", int'(st1), P_AR1);
        cycle();
        chk("ar1_to_hg", int'(st1), P_HG);

        // ---------- reset in the middle of farm yellow, emerg ignored ----------
        do_reset();
        farm = 1'b1;
        run_until(0, P_FY, 200, "reach_fy");
        cycle();
        rst = 1'b1;
        em  = 1'b1;
        cycle();
        chk("rst_fy_state", int'(st1), P_SRST);
        chk("rst_fy_timer", int'(tm1), 0);
        chk("rst_fy_lamps", int'({hw1, fm1}), 5);
        cycle();
        chk("rst_emerg_state", int'(st1), P_SRST);
        rst  = 1'b0;
        em   = 1'b0;
        farm = 1'b0;
        cycle();
        chk("rst_release_ar1", int'(st1), P_AR1);

        // ---------- TICK_DIV=4 instance ----------
        do_reset();
        repeat (110) cycle();
        tcount = 0;
        for (int i = 0; i < 40; i++) begin
            cycle();
            if (tk4) tcount++;
        end
        chk("div4_tick_count", tcount, 10);
        chk("div4_hg_state", int'(st4), P_HG);
        chk("div4_timer_sat", int'(tm4), 31);
        farm = 1'b1;
        run_until(1, P_HY, 20, "div4_reach_hy");
        count_in(1, P_HY, 40, n);
        chk("div4_hy_len", n, 4 * HWY_YEL_T);

        // ---------- randomised traffic against the model ----------
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if (em) em = ($urandom_range(0, 99) < 20) ? 1'b0 : 1'b1;
            else    em = ($urandom_range(0, 99) < 2)  ? 1'b1 : 1'b0;
            if ($urandom_range(0, 99) < 10) farm = ~farm;
            rst = ($urandom_range(0, 999) < 3) ? 1'b1 : 1'b0;
            cycle();
            total++;
            if ((hw1 == 2'b11 && fm1 == 2'b11) || (hw4 == 2'b11 && fm4 == 2'b11)) begin
                bad++;
                $display("FAIL both_green: d1 %b/%b d4 %b/%b (cycle %0d)", hw1, fm1, hw4, fm4, ncyc);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
